bcd_alu: RTL

Sequential signed-magnitude arithmetic unit for the keypad calculator. It sits downstream of the operand and operator registers and upstream of the display mux. On an `execute` strobe from the control FSM it takes two 3-digit BCD operands with sign flags and a 2-bit operator. It returns a 3-digit BCD result with sign, overflow and error flags, and a one-cycle `done` strobe.

---
 rtl/bcd_alu.sv | 135 +++++++++++++
 1 files changed

// File: rtl/bcd_alu.sv
// bcd_alu: sequential signed-magnitude BCD add/sub/mul/div unit for the keypad calculator
// Ports: clock, reset_n (sync, active low), clear (sync, active high), execute (start strobe),
//   operator (00 add, 01 sub, 10 mul, 11 div), a_bcd/b_bcd + a_neg/b_neg (3-digit signed operands),
//   r_bcd/r_neg (result), overflow (|result| > 999), error (divide by zero), busy, done (1-cycle pulse).
module bcd_alu #(
  parameter int WIDTH = 10
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        execute,
  input  logic [1:0]  operator,
  input  logic [11:0] a_bcd,
  input  logic [11:0] b_bcd,
  input  logic        a_neg,
  input  logic        b_neg,
  output logic [11:0] r_bcd,
  output logic        r_neg,
  output logic        overflow,
  output logic        error,
  output logic        busy,
  output logic        done
);
  localparam int P = 2 * WIDTH;
  typedef enum logic [2:0] {IDLE, LOAD, EXEC, CHECK, DABBLE, DONE} state_t;
  state_t state, state_n;
  logic rst;
  logic [11:0] a_d, b_d, adj;
  logic a_s, b_s, sgn, ovf, err, eb, gt, ssgn, qb, err_c, ovf_c, kill, neg_c;
  logic [1:0] op;
  logic [P-1:0] x, acc, sum, rem_t, res;
  logic [WIDTH-1:0] y;
  logic [9:0] bin;
  logic [3:0] cnt;
  logic [21:0] dab, dab_n;
  function automatic logic [WIDTH-1:0] to_bin(input logic [11:0] d);
    logic [3:0] h, t, u;
    h = d[11:8] > 4'd9 ? 4'd9 : d[11:8];
    t = d[7:4] > 4'd9 ? 4'd9 : d[7:4];
    u = d[3:0] > 4'd9 ? 4'd9 : d[3:0];
    return WIDTH'(h) * WIDTH'(100) + WIDTH'(t) * WIDTH'(10) + WIDTH'(u);
  endfunction
  assign rst = !reset_n || clear;
  assign busy = state != IDLE && state != DONE;
  assign done = state == DONE;
  always_comb begin
    // subtract is add with B's sign flipped; unlike signs subtract smaller from larger
    eb = b_s ^ (op == 2'b01);
    gt = x >= P'(y);
    sum = a_s == eb ? x + P'(y) : gt ? x - P'(y) : P'(y) - x;
    ssgn = (a_s == eb || gt) ? a_s : eb;
    // restoring divide: partial remainder in acc, dividend/quotient shifts through x[9:0]
    rem_t = {acc[P-2:0], x[9]};
    qb = rem_t >= P'(y);
    res = op == 2'b11 ? P'(x[9:0]) : acc;
    err_c = op == 2'b11 && y == '0;
    ovf_c = !err_c && res > P'(999);
    kill = err_c || ovf_c;
    bin = kill ? '0 : res[9:0];
    neg_c = sgn && !kill && res != '0;
    adj = dab[21:10];
    for (int i = 0; i < 3; i++)
      adj[4*i +: 4] = dab[10+4*i +: 4] >= 4'd5 ? dab[10+4*i +: 4] + 4'd3 : dab[10+4*i +: 4];
    dab_n = {adj, dab[9:0]} << 1;
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = execute ? LOAD : IDLE;
      LOAD:    state_n = EXEC;
      EXEC:    state_n = (!op[1] || cnt == 4'd9) ? CHECK : EXEC;
      CHECK:   state_n = DABBLE;
      DABBLE:  state_n = cnt == 4'd9 ? DONE : DABBLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      r_bcd <= '0;
      r_neg <= 1'b0;
      overflow <= 1'b0;
      error <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= state_n != state ? 4'd0 : cnt + 4'd1;
      if (state == DABBLE && cnt == 4'd9) begin
        r_bcd <= dab_n[21:10];
        r_neg <= sgn;
        overflow <= ovf;
        error <= err;
      end
    end
  end
  always_ff @(posedge clock) begin
    case (state)
      IDLE: if (execute) begin
        a_d <= a_bcd;
        b_d <= b_bcd;
        a_s <= a_neg;
        b_s <= b_neg;
        op <= operator;
      end
      LOAD: begin
        x <= P'(to_bin(a_d));
        y <= to_bin(b_d);
        acc <= '0;
      end
      EXEC: begin
        sgn <= op[1] ? a_s ^ b_s : ssgn;
        case (op)
          2'b10: begin
            acc <= acc + (y[0] ? x : '0);
            x <= x << 1;
            y <= y >> 1;
          end
          2'b11: begin
            acc <= qb ? rem_t - P'(y) : rem_t;
            x <= {x[P-2:0], qb};
          end
          default: acc <= sum;
        endcase
      end
      CHECK: begin
        dab <= {12'd0, bin};
        sgn <= neg_c;
        ovf <= ovf_c;
        err <= err_c;
      end
      DABBLE: dab <= dab_n;
      default: ;
    endcase
  end
endmodule
